// File: rtl/rv_id_ex_stage.sv
// ID->EX pipeline register: forwards MEM/WB results into the source operands,
// selects PC/immediate operands and presents registered ALU inputs under valid/ready.
module rv_id_ex_stage #(
  parameter int BUS_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [BUS_W-1:0]  id_pc,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [BUS_W-1:0]  id_rs1_data,
  input  logic [BUS_W-1:0]  id_rs2_data,
  input  logic [BUS_W-1:0]  id_imm,
  input  logic [3:0]        id_alu_op,
  input  logic              id_a_sel_pc,
  input  logic              id_b_sel_imm,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_rd_we,
  input  logic              flush,
  input  logic              mem_rd_we,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [BUS_W-1:0]  mem_rd_data,
  input  logic              wb_rd_we,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [BUS_W-1:0]  wb_rd_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [3:0]        ex_alu_op,
  output logic [BUS_W-1:0]  ex_src_a,
  output logic [BUS_W-1:0]  ex_src_b,
  output logic [BUS_W-1:0]  ex_rs2_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_rd_we
);

  logic              accept;
  logic              wb_snoop;
  logic [BUS_W-1:0]  fwd_rs1;
  logic [BUS_W-1:0]  fwd_rs2;
  logic [REG_AW-1:0] rs1_addr_q;
  logic [REG_AW-1:0] rs2_addr_q;
  logic              a_sel_pc_q;
  logic              b_sel_imm_q;

  // MEM is the younger result, so it wins over WB; x0 always reads as zero.
  function automatic logic [BUS_W-1:0] forward(
    input logic [REG_AW-1:0] addr,
    input logic [BUS_W-1:0]  rf_data,
    input logic              m_we,
    input logic [REG_AW-1:0] m_addr,
    input logic [BUS_W-1:0]  m_data,
    input logic              w_we,
    input logic [REG_AW-1:0] w_addr,
    input logic [BUS_W-1:0]  w_data
  );
    if (addr == '0)                        return '0;
    else if (m_we && (m_addr == addr))     return m_data;
    else if (w_we && (w_addr == addr))     return w_data;
    else                                   return rf_data;
  endfunction

  assign fwd_rs1  = forward(id_rs1_addr, id_rs1_data, mem_rd_we, mem_rd_addr, mem_rd_data,
                            wb_rd_we, wb_rd_addr, wb_rd_data);
  assign fwd_rs2  = forward(id_rs2_addr, id_rs2_data, mem_rd_we, mem_rd_addr, mem_rd_data,
                            wb_rd_we, wb_rd_addr, wb_rd_data);
  assign id_ready = ~ex_valid | ex_ready;
  assign accept   = id_valid & id_ready;
  assign wb_snoop = wb_rd_we && (wb_rd_addr != '0);

  // Flush beats accept, accept beats drain; a stalled instruction keeps
  // snooping WB so its register operands stay current while it waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_alu_op   <= 4'b0000;
      ex_src_a    <= '0;
      ex_src_b    <= '0;
      ex_rs2_data <= '0;
      ex_rd_addr  <= '0;
      ex_rd_we    <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      a_sel_pc_q  <= 1'b0;
      b_sel_imm_q <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_rd_we <= 1'b0;
    end else if (accept) begin
      ex_valid    <= 1'b1;
      ex_alu_op   <= id_alu_op;
      ex_src_a    <= id_a_sel_pc  ? id_pc  : fwd_rs1;
      ex_src_b    <= id_b_sel_imm ? id_imm : fwd_rs2;
      ex_rs2_data <= fwd_rs2;
      ex_rd_addr  <= id_rd_addr;
      ex_rd_we    <= id_rd_we;
      rs1_addr_q  <= id_rs1_addr;
      rs2_addr_q  <= id_rs2_addr;
      a_sel_pc_q  <= id_a_sel_pc;
      b_sel_imm_q <= id_b_sel_imm;
    end else if (ex_valid && ex_ready) begin
      ex_valid <= 1'b0;
      ex_rd_we <= 1'b0;
    end else if (ex_valid && wb_snoop) begin
      if (!a_sel_pc_q && (rs1_addr_q == wb_rd_addr))
        ex_src_a <= wb_rd_data;
      // Store data is register-sourced even when srcB takes the immediate.
      if (rs2_addr_q == wb_rd_addr) begin
        ex_rs2_data <= wb_rd_data;
        if (!b_sel_imm_q)
          ex_src_b <= wb_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_rv_id_ex_stage.sv
// Directed self-checking bench for rv_id_ex_stage: forwarding priority, x0,
// operand select, hold with WB snoop, drain, flush, streaming and async reset.
module tb_rv_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [3:0]  id_alu_op;
  logic        id_a_sel_pc;
  logic        id_b_sel_imm;
  logic [4:0]  id_rd_addr;
  logic        id_rd_we;
  logic        flush;
  logic        mem_rd_we;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        wb_rd_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_src_a;
  logic [31:0] ex_src_b;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_we;

  int checks = 0;
  int errors = 0;

  rv_id_ex_stage #(.BUS_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_a_sel_pc(id_a_sel_pc), .id_b_sel_imm(id_b_sel_imm),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .flush(flush),
    .mem_rd_we(mem_rd_we), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_op(ex_alu_op),
    .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_rs2_data(ex_rs2_data),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [31:0] d1, input logic [4:0] rs2,
                                input logic [31:0] d2, input logic [31:0] imm,
                                input logic [3:0] op, input logic asel,
                                input logic bsel, input logic [4:0] rd,
                                input logic we);
    id_valid     = 1'b1;
    id_pc        = pc;
    id_rs1_addr  = rs1;
    id_rs1_data  = d1;
    id_rs2_addr  = rs2;
    id_rs2_data  = d2;
    id_imm       = imm;
    id_alu_op    = op;
    id_a_sel_pc  = asel;
    id_b_sel_imm = bsel;
    id_rd_addr   = rd;
    id_rd_we     = we;
  endtask

  task automatic set_bypass(input logic mwe, input logic [4:0] maddr, input logic [31:0] mdata,
                            input logic wwe, input logic [4:0] waddr, input logic [31:0] wdata);
    mem_rd_we   = mwe;
    mem_rd_addr = maddr;
    mem_rd_data = mdata;
    wb_rd_we    = wwe;
    wb_rd_addr  = waddr;
    wb_rd_data  = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_valid"}, {31'b0, ex_valid}, 32'h0);
    check_output({tag, "_op"}, {28'b0, ex_alu_op}, 32'h0);
    check_output({tag, "_src_a"}, ex_src_a, 32'h0);
    check_output({tag, "_src_b"}, ex_src_b, 32'h0);
    check_output({tag, "_rs2_data"}, ex_rs2_data, 32'h0);
    check_output({tag, "_rd_addr"}, {27'b0, ex_rd_addr}, 32'h0);
    check_output({tag, "_rd_we"}, {31'b0, ex_rd_we}, 32'h0);
    check_output({tag, "_id_ready"}, {31'b0, id_ready}, 32'h1);
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    apply_stimulus(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    id_valid = 1'b0;
    set_bypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #12;
    check_all_zero("reset");
    #10 rst_n = 1'b1;

    // Plain ADD x3 = x1 + x2
    apply_stimulus(32'h40, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 4'h0, 1'b0, 1'b0, 5'd3, 1'b1);
    tick();
    check_output("t1_valid", {31'b0, ex_valid}, 32'h1);
    check_output("t1_src_a", ex_src_a, 32'd5);
    check_output("t1_src_b", ex_src_b, 32'd7);
    check_output("t1_op", {28'b0, ex_alu_op}, 32'h0);
    check_output("t1_rd_addr", {27'b0, ex_rd_addr}, 32'd3);
    check_output("t1_rd_we", {31'b0, ex_rd_we}, 32'h1);

    // MEM and WB both target x1: MEM wins
    set_bypass(1'b1, 5'd1, 32'h10, 1'b1, 5'd1, 32'h20);
    tick();
    check_output("t2_mem_wins", ex_src_a, 32'h10);
    check_output("t2_src_b_rf", ex_src_b, 32'd7);

    // WB-only forward on rs2, MEM targets an unrelated register
    apply_stimulus(32'h44, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 4'h8, 1'b0, 1'b0, 5'd4, 1'b1);
    set_bypass(1'b1, 5'd3, 32'h99, 1'b1, 5'd2, 32'h33);
    tick();
    check_output("t2_src_a_rf", ex_src_a, 32'd5);
    check_output("t2_wb_src_b", ex_src_b, 32'h33);
    check_output("t2_wb_rs2_data", ex_rs2_data, 32'h33);
    check_output("t2_op_sub", {28'b0, ex_alu_op}, 32'h8);

    // x0 sources ignore register-file data and bypass traffic to address 0
    apply_stimulus(32'h48, 5'd0, 32'hAB, 5'd0, 32'hCD, 32'h0, 4'h0, 1'b0, 1'b0, 5'd5, 1'b1);
    set_bypass(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
    tick();
    check_output("t3_x0_src_a", ex_src_a, 32'h0);
    check_output("t3_x0_src_b", ex_src_b, 32'h0);
    check_output("t3_x0_rs2_data", ex_rs2_data, 32'h0);

    // PC and immediate select; store data still the forwarded rs2
    apply_stimulus(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 32'hFFFF_FFF0, 4'h0, 1'b1, 1'b1, 5'd6, 1'b1);
    set_bypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    check_output("t3_pc_src_a", ex_src_a, 32'h100);
    check_output("t3_imm_src_b", ex_src_b, 32'hFFFF_FFF0);
    check_output("t3_rs2_data", ex_rs2_data, 32'd7);

    // Hold: accept, then stall three cycles with a WB hit on rs2 in cycle 2
    apply_stimulus(32'h200, 5'd1, 32'h11, 5'd5, 32'h22, 32'h0, 4'h7, 1'b0, 1'b0, 5'd6, 1'b1);
    tick();
    ex_ready = 1'b0;
    apply_stimulus(32'h204, 5'd9, 32'hDEAD, 5'd10, 32'hBEEF, 32'h0, 4'h3, 1'b0, 1'b0, 5'd11, 1'b1);
    #1;
    check_output("t4_id_ready_low", {31'b0, id_ready}, 32'h0);
    tick();
    check_output("t4_c1_src_b", ex_src_b, 32'h22);
    set_bypass(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h55);
    tick();
    check_output("t4_c2_src_b_snoop", ex_src_b, 32'h55);
    check_output("t4_c2_rs2_data_snoop", ex_rs2_data, 32'h55);
    check_output("t4_c2_src_a", ex_src_a, 32'h11);
    check_output("t4_c2_op", {28'b0, ex_alu_op}, 32'h7);
    check_output("t4_c2_rd_addr", {27'b0, ex_rd_addr}, 32'd6);
    check_output("t4_c2_valid", {31'b0, ex_valid}, 32'h1);
    // MEM traffic is not snooped while holding
    set_bypass(1'b1, 5'd5, 32'h99, 1'b0, 5'd0, 32'h0);
    tick();
    check_output("t4_c3_src_b", ex_src_b, 32'h55);
    check_output("t4_c3_rd_we", {31'b0, ex_rd_we}, 32'h1);
    set_bypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Drain
    ex_ready = 1'b1;
    id_valid = 1'b0;
    tick();
    check_output("drain_valid", {31'b0, ex_valid}, 32'h0);
    check_output("drain_rd_we", {31'b0, ex_rd_we}, 32'h0);
    check_output("drain_id_ready", {31'b0, id_ready}, 32'h1);

    // Flush together with an incoming instruction
    apply_stimulus(32'h300, 5'd1, 32'd1, 5'd2, 32'd2, 32'h0, 4'h0, 1'b0, 1'b0, 5'd7, 1'b1);
    tick();
    check_output("t5_pre_valid", {31'b0, ex_valid}, 32'h1);
    flush = 1'b1;
    apply_stimulus(32'h304, 5'd3, 32'd3, 5'd4, 32'd4, 32'h0, 4'h1, 1'b0, 1'b0, 5'd8, 1'b1);
    tick();
    check_output("t5_flush_valid", {31'b0, ex_valid}, 32'h0);
    check_output("t5_flush_rd_we", {31'b0, ex_rd_we}, 32'h0);
    flush = 1'b0;

    // Flush while holding: id_ready stays low, instruction is killed
    apply_stimulus(32'h308, 5'd1, 32'd1, 5'd2, 32'd2, 32'h0, 4'h0, 1'b0, 1'b0, 5'd9, 1'b1);
    tick();
    ex_ready = 1'b0;
    flush    = 1'b1;
    #1;
    check_output("t5_hold_flush_id_ready", {31'b0, id_ready}, 32'h0);
    tick();
    check_output("t5_hold_flush_valid", {31'b0, ex_valid}, 32'h0);
    check_output("t5_hold_flush_rd_we", {31'b0, ex_rd_we}, 32'h0);
    flush    = 1'b0;
    ex_ready = 1'b1;

    // Back-to-back stream, one result per cycle
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(32'h400 + 32'(i * 4), 5'd1, 32'd100 + 32'(i), 5'd2, 32'd200 + 32'(i),
                     32'h0, 4'h0, 1'b0, 1'b0, 5'd10, 1'b1);
      tick();
      check_output($sformatf("t5_stream%0d_valid", i), {31'b0, ex_valid}, 32'h1);
      check_output($sformatf("t5_stream%0d_src_a", i), ex_src_a, 32'd100 + 32'(i));
      check_output($sformatf("t5_stream%0d_src_b", i), ex_src_b, 32'd200 + 32'(i));
    end

    // Asynchronous reset during a hold
    ex_ready = 1'b0;
    id_valid = 1'b0;
    tick();
    check_output("t6_held_valid", {31'b0, ex_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    #2 rst_n = 1'b1;
    ex_ready = 1'b1;
    apply_stimulus(32'h40, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 4'h0, 1'b0, 1'b0, 5'd3, 1'b1);
    tick();
    check_output("t6_post_valid", {31'b0, ex_valid}, 32'h1);
    check_output("t6_post_src_a", ex_src_a, 32'd5);
    check_output("t6_post_src_b", ex_src_b, 32'd7);
    check_output("t6_post_rd_we", {31'b0, ex_rd_we}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
